// File: rtl/switch_pkg.sv
// Shared types and constants for the 4-port packet switch output scheduler.
// Helper functions convert arbiter grants into port ids.
package switch_pkg;

    localparam int NUM_PORTS = 4;
    localparam int ADDR_W    = 2;
    localparam int DATA_W    = 8;
    localparam int CNT_W     = 16;

    typedef logic [ADDR_W-1:0] port_id_t;

    typedef struct packed {
        port_id_t              source;
        port_id_t              target;
        logic [DATA_W-1:0]     data;
    } pkt_t;

    // One-hot grant vector to the index of its set bit.
    function automatic port_id_t onehot_to_id(input logic [NUM_PORTS-1:0] oh);
        port_id_t id;
        id = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            id = id | (oh[i] ? port_id_t'(i) : port_id_t'(0));
        end
        return id;
    endfunction

    // Cyclic successor of a port id.
    function automatic port_id_t next_id(input port_id_t id);
        port_id_t nxt;
        if (id == port_id_t'(NUM_PORTS - 1)) begin
            nxt = '0;
        end else begin
            nxt = id + port_id_t'(1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr,
// searching cyclically. The pointer itself is owned by the caller.
module rr_arbiter
    import switch_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req,
    input  port_id_t             ptr,
    output logic [NUM_PORTS-1:0] gnt,
    output logic                 grant_any
);

    port_id_t idx_s;
    logic     hit_s;

    // Cyclic priority search; once one request hits, later ones are masked.
    always_comb begin
        gnt       = '0;
        grant_any = 1'b0;
        idx_s     = '0;
        hit_s     = 1'b0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            idx_s      = port_id_t'((int'(ptr) + k) % NUM_PORTS);
            hit_s      = req[idx_s] & ~grant_any;
            gnt[idx_s] = gnt[idx_s] | hit_s;
            grant_any  = grant_any | hit_s;
        end
    end

endmodule

// File: rtl/switch_arbiter.sv
// Per-output round-robin scheduler with a one-entry output slot per port.
// Self-targeted packets are consumed immediately and counted as drops.
module switch_arbiter
    import switch_pkg::*;
(
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_PORTS-1:0]              req_valid,
    input  logic [NUM_PORTS-1:0][ADDR_W-1:0]  req_source,
    input  logic [NUM_PORTS-1:0][ADDR_W-1:0]  req_target,
    input  logic [NUM_PORTS-1:0][DATA_W-1:0]  req_data,
    output logic [NUM_PORTS-1:0]              req_ready,
    output logic [NUM_PORTS-1:0]              out_valid,
    output logic [NUM_PORTS-1:0][ADDR_W-1:0]  out_source,
    output logic [NUM_PORTS-1:0][ADDR_W-1:0]  out_target,
    output logic [NUM_PORTS-1:0][DATA_W-1:0]  out_data,
    input  logic [NUM_PORTS-1:0]              out_ready,
    output logic [CNT_W-1:0]                  drop_cnt
);

    logic [NUM_PORTS-1:0] valid_q, valid_d;
    pkt_t                 slot_q [NUM_PORTS];
    pkt_t                 slot_d [NUM_PORTS];
    port_id_t             ptr_q  [NUM_PORTS];
    port_id_t             ptr_d  [NUM_PORTS];
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic [NUM_PORTS-1:0] cand_s [NUM_PORTS];
    logic [NUM_PORTS-1:0] gnt_s  [NUM_PORTS];
    port_id_t             win_s  [NUM_PORTS];
    logic [NUM_PORTS-1:0] any_s;
    logic [NUM_PORTS-1:0] slot_free_s;
    logic [NUM_PORTS-1:0] grant_s;
    logic [NUM_PORTS-1:0] self_s;
    logic [ADDR_W:0]      drops_s;
    logic [CNT_W:0]       sum_s;

    // Candidate requesters per output, and self-targeted inputs.
    always_comb begin
        self_s = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            cand_s[o] = '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                cand_s[o][i] = req_valid[i] && (req_target[i] == port_id_t'(o)) && (i != o);
            end
        end
        for (int i = 0; i < NUM_PORTS; i++) begin
            self_s[i] = req_valid[i] && (req_target[i] == port_id_t'(i));
        end
    end

    for (genvar o = 0; o < NUM_PORTS; o++) begin : g_arb
        rr_arbiter u_arb (
            .req       (cand_s[o]),
            .ptr       (ptr_q[o]),
            .gnt       (gnt_s[o]),
            .grant_any (any_s[o])
        );
    end

    // A slot accepts when empty or draining this cycle; nothing is granted in reset.
    always_comb begin
        slot_free_s = ~valid_q | out_ready;
        grant_s     = any_s & slot_free_s & {NUM_PORTS{~rst}};
        for (int o = 0; o < NUM_PORTS; o++) begin
            win_s[o] = onehot_to_id(gnt_s[o]);
        end
    end

    // Ready is the OR of every output that picked this input, plus self-drop.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            req_ready[i] = self_s[i];
            for (int o = 0; o < NUM_PORTS; o++) begin
                req_ready[i] = req_ready[i] | (grant_s[o] & gnt_s[o][i]);
            end
            req_ready[i] = req_ready[i] & ~rst;
        end
    end

    // Slot next state: a grant refills even while the old contents drain.
    always_comb begin
        valid_d = valid_q;
        slot_d  = slot_q;
        ptr_d   = ptr_q;
        for (int o = 0; o < NUM_PORTS; o++) begin
            if (grant_s[o]) begin
                slot_d[o].source = req_source[win_s[o]];
                slot_d[o].target = req_target[win_s[o]];
                slot_d[o].data   = req_data[win_s[o]];
                valid_d[o]       = 1'b1;
                ptr_d[o]         = next_id(win_s[o]);
            end else if (out_ready[o]) begin
                valid_d[o] = 1'b0;
            end else begin
                valid_d[o] = valid_q[o];
            end
        end
    end

    // Saturating drop counter; the extra sum bit flags overflow.
    always_comb begin
        drops_s = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            drops_s = drops_s + {{ADDR_W{1'b0}}, self_s[i]};
        end
        sum_s = {1'b0, cnt_q} + {{(CNT_W - ADDR_W){1'b0}}, drops_s};
        if (sum_s[CNT_W]) begin
            cnt_d = '1;
        end else begin
            cnt_d = sum_s[CNT_W-1:0];
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            cnt_q   <= '0;
            for (int o = 0; o < NUM_PORTS; o++) begin
                slot_q[o] <= '0;
                ptr_q[o]  <= '0;
            end
        end else begin
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            for (int o = 0; o < NUM_PORTS; o++) begin
                slot_q[o] <= slot_d[o];
                ptr_q[o]  <= ptr_d[o];
            end
        end
    end

    // Outputs come straight from the slot registers.
    always_comb begin
        out_valid  = valid_q;
        out_source = '0;
        out_target = '0;
        out_data   = '0;
        drop_cnt   = cnt_q;
        for (int o = 0; o < NUM_PORTS; o++) begin
            out_source[o] = slot_q[o].source;
            out_target[o] = slot_q[o].target;
            out_data[o]   = slot_q[o].data;
        end
    end

endmodule

// File: tb/tb_switch_arbiter.sv
// Directed bench for switch_arbiter: reset, single path, contention, backpressure,
// self-target drops with saturation, and reset during traffic.
module tb_switch_arbiter;

    logic             clk = 1'b0;
    logic             rst;
    logic [3:0]       req_valid;
    logic [3:0][1:0]  req_source;
    logic [3:0][1:0]  req_target;
    logic [3:0][7:0]  req_data;
    logic [3:0]       req_ready;
    logic [3:0]       out_valid;
    logic [3:0][1:0]  out_source;
    logic [3:0][1:0]  out_target;
    logic [3:0][7:0]  out_data;
    logic [3:0]       out_ready;
    logic [15:0]      drop_cnt;

    int checks = 0;
    int passed = 0;

    switch_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_source (req_source),
        .req_target (req_target),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .out_valid  (out_valid),
        .out_source (out_source),
        .out_target (out_target),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_valid  = '0;
        req_source = '0;
        req_target = '0;
        req_data   = '0;
    endtask

    task automatic set_req(input int i, input int src, input int tgt, input logic [7:0] d);
        req_valid[i]  = 1'b1;
        req_source[i] = 2'(src);
        req_target[i] = 2'(tgt);
        req_data[i]   = d;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        idle();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        out_ready = 4'hF;
        idle();
        for (int i = 0; i < 4; i++) set_req(i, i, (i + 1) % 4, 8'h30 + 8'(i));
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if (req_ready !== 4'h0) $display("FAIL reset_ready got=%b exp=0000", req_ready);
            else passed++;
            checks++;
            if (out_valid !== 4'h0) $display("FAIL reset_out_valid got=%b exp=0000", out_valid);
            else passed++;
            checks++;
            if (drop_cnt !== 16'h0) $display("FAIL reset_drop_cnt got=%h exp=0000", drop_cnt);
            else passed++;
        end
        rst = 1'b0;
        idle();
        tick();
        checks++;
        if (out_valid !== 4'h0) $display("FAIL post_reset_valid got=%b exp=0000", out_valid);
        else passed++;
        checks++;
        if (out_source !== 8'h00) $display("FAIL post_reset_source got=%h exp=00", out_source);
        else passed++;
        checks++;
        if (out_target !== 8'h00) $display("FAIL post_reset_target got=%h exp=00", out_target);
        else passed++;
        checks++;
        if (out_data !== 32'h0) $display("FAIL post_reset_data got=%h exp=00000000", out_data);
        else passed++;
    endtask

    task automatic test_single_path();
        out_ready = 4'b0100;
        set_req(1, 1, 2, 8'hA5);
        #1;
        checks++;
        if (req_ready !== 4'b0010) $display("FAIL single_ready got=%b exp=0010", req_ready);
        else passed++;
        tick();
        idle();
        checks++;
        if (out_valid !== 4'b0100) $display("FAIL single_valid got=%b exp=0100", out_valid);
        else passed++;
        checks++;
        if (out_data[2] !== 8'hA5) $display("FAIL single_data got=%h exp=a5", out_data[2]);
        else passed++;
        checks++;
        if (out_source[2] !== 2'd1) $display("FAIL single_source got=%0d exp=1", out_source[2]);
        else passed++;
        checks++;
        if (out_target[2] !== 2'd2) $display("FAIL single_target got=%0d exp=2", out_target[2]);
        else passed++;
        out_ready = 4'hF;
        tick();
        checks++;
        if (out_valid !== 4'h0) $display("FAIL single_drain got=%b exp=0000", out_valid);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int         exp_ord [6] = '{0, 1, 3, 0, 1, 3};
        logic [3:0] exp_oh;
        pulse_reset();
        out_ready = 4'hF;
        set_req(0, 0, 2, 8'h10);
        set_req(1, 1, 2, 8'h11);
        set_req(3, 3, 2, 8'h13);
        for (int k = 0; k < 6; k++) begin
            exp_oh = 4'b0001 << exp_ord[k];
            #1;
            checks++;
            if (req_ready !== exp_oh) $display("FAIL rr_grant[%0d] got=%b exp=%b", k, req_ready, exp_oh);
            else passed++;
            tick();
            checks++;
            if (out_valid !== 4'b0100) $display("FAIL rr_valid[%0d] got=%b exp=0100", k, out_valid);
            else passed++;
            checks++;
            if (out_source[2] !== 2'(exp_ord[k]) || out_data[2] !== 8'h10 + 8'(exp_ord[k]))
                $display("FAIL rr_pkt[%0d] got=%0d/%h exp=%0d/%h", k, out_source[2], out_data[2],
                         exp_ord[k], 8'h10 + 8'(exp_ord[k]));
            else passed++;
        end
    endtask

    task automatic test_backpressure();
        out_ready = 4'b1011;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if (req_ready !== 4'h0) $display("FAIL bp_ready[%0d] got=%b exp=0000", c, req_ready);
            else passed++;
            tick();
            checks++;
            if (out_valid[2] !== 1'b1 || out_data[2] !== 8'h13)
                $display("FAIL bp_hold[%0d] got=%b/%h exp=1/13", c, out_valid[2], out_data[2]);
            else passed++;
        end
        out_ready = 4'hF;
        #1;
        checks++;
        if (req_ready !== 4'b0001) $display("FAIL bp_release got=%b exp=0001", req_ready);
        else passed++;
        tick();
        checks++;
        if (out_source[2] !== 2'd0 || out_data[2] !== 8'h10)
            $display("FAIL bp_reload got=%0d/%h exp=0/10", out_source[2], out_data[2]);
        else passed++;
        idle();
        tick();
        checks++;
        if (out_valid !== 4'h0) $display("FAIL bp_drain got=%b exp=0000", out_valid);
        else passed++;
    endtask

    task automatic test_self_target();
        set_req(3, 3, 3, 8'h77);
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (req_ready !== 4'b1000) $display("FAIL self_ready[%0d] got=%b exp=1000", c, req_ready);
            else passed++;
            tick();
            checks++;
            if (out_valid[3] !== 1'b0) $display("FAIL self_valid[%0d] got=%b exp=0", c, out_valid[3]);
            else passed++;
        end
        idle();
        checks++;
        if (drop_cnt !== 16'd3) $display("FAIL self_drop_cnt got=%0d exp=3", drop_cnt);
        else passed++;
    endtask

    task automatic test_reset_mid();
        out_ready = 4'h0;
        set_req(0, 0, 1, 8'hA0);
        set_req(1, 1, 2, 8'hA1);
        set_req(2, 2, 3, 8'hA2);
        set_req(3, 3, 0, 8'hA3);
        #1;
        checks++;
        if (req_ready !== 4'hF) $display("FAIL mid_fill_ready got=%b exp=1111", req_ready);
        else passed++;
        tick();
        checks++;
        if (out_valid !== 4'hF) $display("FAIL mid_full got=%b exp=1111", out_valid);
        else passed++;
        rst = 1'b1;
        idle();
        tick();
        rst = 1'b0;
        checks++;
        if (out_valid !== 4'h0) $display("FAIL mid_reset_valid got=%b exp=0000", out_valid);
        else passed++;
        out_ready = 4'hF;
        for (int i = 0; i < 4; i++) set_req(i, i, 0, 8'hB0 + 8'(i));
        #1;
        checks++;
        if (req_ready !== 4'b0011) $display("FAIL mid_first_grant got=%b exp=0011", req_ready);
        else passed++;
        tick();
        idle();
        checks++;
        if (out_valid !== 4'b0001 || out_source[0] !== 2'd1 || out_data[0] !== 8'hB1)
            $display("FAIL mid_first_pkt got=%b/%0d/%h exp=0001/1/b1", out_valid, out_source[0], out_data[0]);
        else passed++;
        checks++;
        if (drop_cnt !== 16'd1) $display("FAIL mid_drop_cnt got=%0d exp=1", drop_cnt);
        else passed++;
    endtask

    task automatic test_drop_saturation();
        pulse_reset();
        for (int i = 0; i < 4; i++) set_req(i, i, i, 8'h00);
        repeat (16383) tick();
        checks++;
        if (drop_cnt !== 16'hFFFC) $display("FAIL sat_near got=%h exp=fffc", drop_cnt);
        else passed++;
        req_valid = 4'b0011;
        tick();
        checks++;
        if (drop_cnt !== 16'hFFFE) $display("FAIL sat_add2 got=%h exp=fffe", drop_cnt);
        else passed++;
        req_valid = 4'hF;
        tick();
        checks++;
        if (drop_cnt !== 16'hFFFF) $display("FAIL sat_cross got=%h exp=ffff", drop_cnt);
        else passed++;
        tick();
        checks++;
        if (drop_cnt !== 16'hFFFF) $display("FAIL sat_hold got=%h exp=ffff", drop_cnt);
        else passed++;
        checks++;
        if (out_valid !== 4'h0) $display("FAIL sat_no_delivery got=%b exp=0000", out_valid);
        else passed++;
        idle();
    endtask

    initial begin
        rst       = 1'b1;
        out_ready = 4'hF;
        idle();
        test_reset();
        test_single_path();
        test_back_to_back();
        test_backpressure();
        test_self_target();
        test_reset_mid();
        test_drop_saturation();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
